// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Zero-latency lookup at fetch; training from resolved branches in MEM.
module branch_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned MODE    = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_pc,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        update_mispred,
    input  logic        stall,
    input  logic        invalidate,
    output logic [31:0] mispred_cnt,
    output logic [31:0] update_cnt
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             fetch_hit;
    logic             upd_hit;
    logic             accept;
    logic             unused_pc_lsbs;

    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign fetch_tag = fetch_pc[31:IDX_W+2];
    assign upd_idx   = update_pc[IDX_W+1:2];
    assign upd_tag   = update_pc[31:IDX_W+2];

    // Instruction addresses are word aligned; the low bits never select anything.
    assign unused_pc_lsbs = ^{fetch_pc[1:0], update_pc[1:0]};

    assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign accept    = update_en && !stall && !invalidate;

    always_comb begin
        pred_taken = 1'b0;
        if (MODE == 1) begin
            pred_taken = fetch_hit && ctr_q[fetch_idx][1];
        end
        pred_pc = pred_taken ? target_q[fetch_idx] : fetch_pc + 32'd4;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (MODE == 1) begin
            if (invalidate) begin
                // Only valid bits clear; counters keep their history.
                for (int unsigned i = 0; i < ENTRIES; i++) begin
                    valid_q[i] <= 1'b0;
                end
            end else if (accept) begin
                if (upd_hit) begin
                    if (update_taken) begin
                        target_q[upd_idx] <= update_target;
                        if (ctr_q[upd_idx] != 2'b11) begin
                            ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
                        end
                    end else if (ctr_q[upd_idx] != 2'b00) begin
                        ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
                    end
                end else if (update_taken) begin
                    valid_q[upd_idx]  <= 1'b1;
                    tag_q[upd_idx]    <= upd_tag;
                    target_q[upd_idx] <= update_target;
                    ctr_q[upd_idx]    <= 2'b10;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            update_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (accept) begin
            update_cnt <= update_cnt + 32'd1;
            if (update_mispred) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a bimodal instance and a static
// instance share every input so both modes see the same update stream.
module tb_branch_predictor;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] fetch_pc;
    logic        update_en;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_mispred;
    logic        stall;
    logic        invalidate;

    logic        pred_taken;
    logic [31:0] pred_pc;
    logic [31:0] mispred_cnt;
    logic [31:0] update_cnt;
    logic        s_pred_taken;
    logic [31:0] s_pred_pc;
    logic [31:0] s_mispred_cnt;
    logic [31:0] s_update_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] exp_upd = '0;
    logic [31:0] exp_mis = '0;

    always #5 CLK = ~CLK;

    branch_predictor #(.ENTRIES(16), .MODE(1)) dut (
        .CLK(CLK), .nRST(nRST), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_pc(pred_pc),
        .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_mispred(update_mispred),
        .stall(stall), .invalidate(invalidate),
        .mispred_cnt(mispred_cnt), .update_cnt(update_cnt)
    );

    branch_predictor #(.ENTRIES(16), .MODE(0)) dut_static (
        .CLK(CLK), .nRST(nRST), .fetch_pc(fetch_pc),
        .pred_taken(s_pred_taken), .pred_pc(s_pred_pc),
        .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_mispred(update_mispred),
        .stall(stall), .invalidate(invalidate),
        .mispred_cnt(s_mispred_cnt), .update_cnt(s_update_cnt)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp_t, input logic [31:0] exp_pc);
        fetch_pc = pc;
        #1;
        check({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, exp_t});
        check({tag, ".pc"}, pred_pc, exp_pc);
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic mis, input logic stl, input logic inv);
        @(negedge CLK);
        update_en      = 1'b1;
        update_pc      = pc;
        update_taken   = tk;
        update_target  = tgt;
        update_mispred = mis;
        stall          = stl;
        invalidate     = inv;
        if (!stl && !inv) begin
            exp_upd = exp_upd + 32'd1;
            if (mis) exp_mis = exp_mis + 32'd1;
        end
        @(posedge CLK);
        #1;
        update_en  = 1'b0;
        stall      = 1'b0;
        invalidate = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check({tag, ".upd"}, update_cnt, exp_upd);
        check({tag, ".mis"}, mispred_cnt, exp_mis);
        check({tag, ".s_upd"}, s_update_cnt, exp_upd);
        check({tag, ".s_mis"}, s_mispred_cnt, exp_mis);
    endtask

    initial begin
        nRST = 1'b0;
        fetch_pc = 32'h100;
        update_en = 1'b0;
        update_pc = '0;
        update_taken = 1'b0;
        update_target = '0;
        update_mispred = 1'b0;
        stall = 1'b0;
        invalidate = 1'b0;

        #2;
        look("in_reset", 32'h100, 1'b0, 32'h104);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;

        // Reset state and wrap of the fall-through address
        look("rst_100", 32'h100, 1'b0, 32'h104);
        look("rst_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
        check_counts("rst_cnt");

        // Allocation; lookup in the same cycle sees the old table
        @(negedge CLK);
        update_en = 1'b1; update_pc = 32'h40; update_taken = 1'b1;
        update_target = 32'h80; update_mispred = 1'b1;
        exp_upd = exp_upd + 32'd1; exp_mis = exp_mis + 32'd1;
        look("same_cycle", 32'h40, 1'b0, 32'h44);
        @(posedge CLK);
        #1;
        update_en = 1'b0;
        look("alloc_hit", 32'h40, 1'b1, 32'h80);
        look("alias_miss", 32'h80, 1'b0, 32'h84);
        fetch_pc = 32'h40; #1;
        check("static_never", {31'd0, s_pred_taken}, 32'd0);
        check("static_pc", s_pred_pc, 32'h44);

        // Counter trajectory 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10
        upd(32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        look("ctr01", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        look("ctr00", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        look("ctr00_sat", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
        look("ctr01_up", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
        look("ctr10_up", 32'h40, 1'b1, 32'h80);
        upd(32'h40, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
        look("ctr11", 32'h40, 1'b1, 32'h80);
        upd(32'h40, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
        look("ctr11_sat", 32'h40, 1'b1, 32'h80);
        upd(32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        look("ctr10_dn", 32'h40, 1'b1, 32'h80);

        // Aliased replacement, target rewrite on hit, not-taken misses
        upd(32'h80, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        look("replace_new", 32'h80, 1'b1, 32'h200);
        look("replace_old", 32'h40, 1'b0, 32'h44);
        upd(32'h80, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
        look("retarget", 32'h80, 1'b1, 32'h300);
        upd(32'hC0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        look("nt_miss_new", 32'hC0, 1'b0, 32'hC4);
        look("nt_miss_keep", 32'h80, 1'b1, 32'h300);
        upd(32'h44, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        look("nt_miss_idx1", 32'h44, 1'b0, 32'h48);
        check_counts("mid_cnt");

        // Stall blocks the update and the counters
        upd(32'h44, 1'b1, 32'h500, 1'b1, 1'b1, 1'b0);
        look("stall_miss", 32'h44, 1'b0, 32'h48);
        check_counts("stall_cnt");

        // Invalidate wins over a simultaneous update
        upd(32'h40, 1'b1, 32'h600, 1'b1, 1'b0, 1'b1);
        look("inv_80", 32'h80, 1'b0, 32'h84);
        look("inv_40", 32'h40, 1'b0, 32'h44);
        check_counts("inv_cnt");

        // Counter section from a clean asynchronous reset
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        exp_upd = '0; exp_mis = '0;
        check_counts("async_rst");
        #2;
        nRST = 1'b1;
        upd(32'h40, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0);
        upd(32'h44, 1'b1, 32'h90, 1'b0, 1'b0, 1'b0);
        upd(32'h48, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check_counts("three_upd");
        check("three_upd.exp", exp_upd, 32'd3);
        check("three_mis.exp", exp_mis, 32'd2);
        look("cnt_hit", 32'h40, 1'b1, 32'h80);
        check("static_seq", {31'd0, s_pred_taken}, 32'd0);

        // Reset while an update is presented
        @(negedge CLK);
        update_en = 1'b1; update_pc = 32'h40; update_taken = 1'b1;
        update_target = 32'h700; update_mispred = 1'b1;
        #2;
        nRST = 1'b0;
        exp_upd = '0; exp_mis = '0;
        @(posedge CLK);
        #1;
        check_counts("rst_inflight");
        look("rst_inflight", 32'h40, 1'b0, 32'h44);
        @(negedge CLK);
        nRST = 1'b1;
        update_en = 1'b0;
        @(posedge CLK);
        #1;
        look("after_rst", 32'h40, 1'b0, 32'h44);
        check_counts("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
